// File: rtl/seg_cmd_pkg.sv
// Shared constants, FSM encoding and helpers for the UART segment-display controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_cmd_pkg;

  // ASCII command and argument bytes
  localparam logic [7:0] CH_0 = 8'h30;
  localparam logic [7:0] CH_1 = 8'h31;
  localparam logic [7:0] CH_6 = 8'h36;
  localparam logic [7:0] CH_9 = 8'h39;
  localparam logic [7:0] CH_B = 8'h42;
  localparam logic [7:0] CH_C = 8'h43;
  localparam logic [7:0] CH_D = 8'h44;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_R = 8'h52;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARG_DOT   = 2'd1,
    ARG_EN    = 2'd2,
    ARG_BLINK = 2'd3
  } state_t;

  // Digit position '1'..'6' maps to mask bit 5..0 (digit 1 is the leftmost, MSB)
  function automatic logic [2:0] pos_to_bit(input logic [7:0] b);
    logic [7:0] n;
    n = b - CH_0;
    return 3'(8'd6 - n);
  endfunction

endpackage

// File: rtl/seg_blink_timer.sv
// Whole-display blink phase generator: toggles phase every BLINK_HALF cycles while enabled.
// Latency: phase forced high combinationally when disabled; toggles one cycle after the wrap count.
// Backpressure: none; free-running counter.
module seg_blink_timer #(
  parameter int BLINK_HALF = 6000000,
  parameter int CNT_W      = 24
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic blink_en,
  input  logic restart,
  output logic blink_phase
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;

  // Count half-periods while enabled; restart or disable parks the counter with the display lit
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (restart || !blink_en) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (r_cnt == CNT_W'(BLINK_HALF - 1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // A disabled blinker always reads as lit, so turning blink off never leaves a dark cycle
  assign blink_phase = r_phase | ~blink_en;

endmodule

// File: rtl/seg_cmd_ctl.sv
// UART command decoder driving the 6-digit segment display digit/enable/dot registers.
// Latency: one cycle from the rx_data_valid strobe to the updated registered outputs.
// Backpressure: none; every strobed byte is consumed, argument waits are bounded by ARG_TIMEOUT.
module seg_cmd_ctl
  import seg_cmd_pkg::*;
#(
  parameter int BLINK_HALF  = 6000000,
  parameter int ARG_TIMEOUT = 12000000,
  parameter int CNT_W       = 24
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rx_data_valid,
  input  logic [7:0]  rx_data_out,
  output logic [23:0] seg_data,
  output logic [5:0]  seg_data_en,
  output logic [5:0]  seg_dot_en,
  output logic        busy,
  output logic        cmd_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_to_cnt;
  logic [23:0]      r_seg_data;
  logic [5:0]       r_en_mask;
  logic [5:0]       r_dot_en;
  logic             r_blink_en;
  logic             r_cmd_err;
  logic             w_err;
  logic             w_busy;
  logic             w_restart;
  logic             w_blink_phase;
  logic             w_is_digit;
  logic             w_is_pos;
  logic             w_expired;
  logic [2:0]       w_pos;

  assign w_is_digit = (rx_data_out >= CH_0) && (rx_data_out <= CH_9);
  assign w_is_pos   = (rx_data_out >= CH_1) && (rx_data_out <= CH_6);
  assign w_pos      = pos_to_bit(rx_data_out);
  assign w_expired  = (r_to_cnt == CNT_W'(ARG_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next state: command bytes open an argument wait; any byte or expiry closes it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (rx_data_valid) begin
          if      (rx_data_out == CH_D) w_state_nxt = ARG_DOT;
          else if (rx_data_out == CH_E) w_state_nxt = ARG_EN;
          else if (rx_data_out == CH_B) w_state_nxt = ARG_BLINK;
        end
      end
      default: begin
        if (rx_data_valid || w_expired) w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM outputs: error strobe, busy flag and blink restart request
  always_comb begin
    w_err     = 1'b0;
    w_restart = 1'b0;
    w_busy    = (r_state != IDLE);
    case (r_state)
      ARG_DOT, ARG_EN: begin
        if (rx_data_valid) w_err = !w_is_pos;
        else               w_err = w_expired;
      end
      ARG_BLINK: begin
        if (rx_data_valid) begin
          w_restart = (rx_data_out == CH_1);
          w_err     = (rx_data_out != CH_0) && (rx_data_out != CH_1);
        end else begin
          w_err     = w_expired;
        end
      end
      default: ;
    endcase
  end

  // Argument timeout counter: zero in IDLE, counts while waiting for an argument
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)              r_to_cnt <= '0;
    else if (r_state == IDLE)   r_to_cnt <= '0;
    else                        r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Display register file, updated only on strobed bytes; error pulse registered every cycle
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_seg_data <= '0;
      r_en_mask  <= 6'b111111;
      r_dot_en   <= '0;
      r_blink_en <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_cmd_err <= w_err;
      if (rx_data_valid) begin
        case (r_state)
          IDLE: begin
            if (w_is_digit) begin
              r_seg_data <= {r_seg_data[19:0], rx_data_out[3:0]};
            end else if (rx_data_out == CH_C) begin
              r_seg_data <= '0;
            end else if (rx_data_out == CH_R) begin
              r_seg_data <= '0;
              r_en_mask  <= 6'b111111;
              r_dot_en   <= '0;
              r_blink_en <= 1'b0;
            end
          end
          ARG_DOT:   if (w_is_pos) r_dot_en  <= r_dot_en  ^ (6'b000001 << w_pos);
          ARG_EN:    if (w_is_pos) r_en_mask <= r_en_mask ^ (6'b000001 << w_pos);
          ARG_BLINK: begin
            if      (rx_data_out == CH_0) r_blink_en <= 1'b0;
            else if (rx_data_out == CH_1) r_blink_en <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  seg_blink_timer #(
    .BLINK_HALF (BLINK_HALF),
    .CNT_W      (CNT_W)
  ) u_blink (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .blink_en    (r_blink_en),
    .restart     (w_restart),
    .blink_phase (w_blink_phase)
  );

  assign seg_data    = r_seg_data;
  assign seg_data_en = w_blink_phase ? r_en_mask : 6'b000000;
  assign seg_dot_en  = r_dot_en;
  assign busy        = w_busy;
  assign cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_seg_cmd_ctl.sv
// Directed bench for seg_cmd_ctl with a short blink half-period and argument timeout.
// Latency: inputs driven on the falling edge, outputs checked on the following falling edge.
// Backpressure: n/a.
module tb_seg_cmd_ctl;

  logic        clk_in;
  logic        rst_n_in;
  logic        rx_data_valid;
  logic [7:0]  rx_data_out;
  logic [23:0] seg_data;
  logic [5:0]  seg_data_en;
  logic [5:0]  seg_dot_en;
  logic        busy;
  logic        cmd_err;

  int n_assert = 0;
  int n_fail   = 0;

  seg_cmd_ctl #(
    .BLINK_HALF  (8),
    .ARG_TIMEOUT (16),
    .CNT_W       (24)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rx_data_valid (rx_data_valid),
    .rx_data_out   (rx_data_out),
    .seg_data      (seg_data),
    .seg_data_en   (seg_data_en),
    .seg_dot_en    (seg_dot_en),
    .busy          (busy),
    .cmd_err       (cmd_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for a single cycle; idle data is a command byte so stray sampling shows up
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_in);
    rx_data_valid = 1'b1;
    rx_data_out   = b;
    @(negedge clk_in);
    rx_data_valid = 1'b0;
    rx_data_out   = 8'h44;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_in      = 1'b0;
    rx_data_valid = 1'b0;
    rx_data_out   = 8'h44;
    repeat (3) @(negedge clk_in);

    check("rst_data",  seg_data,           24'h0);
    check("rst_en",    24'(seg_data_en),   24'h3F);
    check("rst_dot",   24'(seg_dot_en),    24'h0);
    check("rst_busy",  24'(busy),          24'h0);
    check("rst_err",   24'(cmd_err),       24'h0);
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // Digit shift-in: seven digits, the first one falls off the left
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33); send_byte(8'h34);
    send_byte(8'h35); send_byte(8'h36); send_byte(8'h37);
    check("shift_data", seg_data,         24'h234567);
    check("shift_en",   24'(seg_data_en), 24'h3F);
    check("shift_err",  24'(cmd_err),     24'h0);

    // Clear, then dot toggle on digit 3 twice
    send_byte(8'h43);
    check("clear_data", seg_data, 24'h0);
    send_byte(8'h44);
    check("dot_busy",   24'(busy),       24'h1);
    send_byte(8'h33);
    check("dot3_on",    24'(seg_dot_en), 24'h08);
    check("dot3_idle",  24'(busy),       24'h0);
    send_byte(8'h44); send_byte(8'h33);
    check("dot3_off",   24'(seg_dot_en), 24'h00);

    // Enable toggle on digit 6, then an invalid argument
    send_byte(8'h45); send_byte(8'h36);
    check("en6_off",    24'(seg_data_en), 24'h3E);
    send_byte(8'h45); send_byte(8'h39);
    check("en_bad_err",  24'(cmd_err),     24'h1);
    check("en_bad_mask", 24'(seg_data_en), 24'h3E);
    check("en_bad_busy", 24'(busy),        24'h0);
    @(negedge clk_in);
    check("en_bad_pulse", 24'(cmd_err),    24'h0);
    send_byte(8'h45); send_byte(8'h36);
    check("en6_on",     24'(seg_data_en), 24'h3F);

    // Blink on: 8 cycles lit, 8 cycles dark, repeating
    send_byte(8'h42); send_byte(8'h31);
    for (int j = 0; j < 24; j++) begin
      check($sformatf("blink_%0d", j), 24'(seg_data_en), ((j / 8) % 2 == 0) ? 24'h3F : 24'h0);
      @(negedge clk_in);
    end
    send_byte(8'h42); send_byte(8'h30);
    for (int j = 0; j < 10; j++) begin
      check($sformatf("blink_off_%0d", j), 24'(seg_data_en), 24'h3F);
      @(negedge clk_in);
    end

    // Argument timeout with no byte
    send_byte(8'h44);
    repeat (15) @(negedge clk_in);
    check("to_wait_busy", 24'(busy),    24'h1);
    check("to_wait_err",  24'(cmd_err), 24'h0);
    @(negedge clk_in);
    check("to_err",       24'(cmd_err), 24'h1);
    check("to_busy",      24'(busy),    24'h0);
    @(negedge clk_in);
    check("to_pulse",     24'(cmd_err), 24'h0);

    // Argument arriving exactly on the expiry cycle wins
    send_byte(8'h44);
    repeat (15) @(negedge clk_in);
    rx_data_valid = 1'b1;
    rx_data_out   = 8'h32;
    @(negedge clk_in);
    rx_data_valid = 1'b0;
    rx_data_out   = 8'h44;
    check("edge_dot",  24'(seg_dot_en), 24'h10);
    check("edge_err",  24'(cmd_err),    24'h0);
    check("edge_busy", 24'(busy),       24'h0);

    // Async reset mid-command with blink active
    send_byte(8'h35);
    send_byte(8'h42); send_byte(8'h31);
    send_byte(8'h45);
    repeat (10) @(negedge clk_in);
    check("pre_rst_busy", 24'(busy),        24'h1);
    check("pre_rst_dark", 24'(seg_data_en), 24'h0);
    rst_n_in = 1'b0;
    #1;
    check("arst_data", seg_data,         24'h0);
    check("arst_en",   24'(seg_data_en), 24'h3F);
    check("arst_dot",  24'(seg_dot_en),  24'h0);
    check("arst_busy", 24'(busy),        24'h0);
    check("arst_err",  24'(cmd_err),     24'h0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    send_byte(8'h36);
    check("post_rst_digit", seg_data,         24'h000006);
    check("post_rst_en",    24'(seg_data_en), 24'h3F);
    send_byte(8'h78);
    check("ignore_data", seg_data,     24'h000006);
    check("ignore_err",  24'(cmd_err), 24'h0);
    check("ignore_busy", 24'(busy),    24'h0);

    // Soft reset after configuring digits, dots, enables and blink
    send_byte(8'h39); send_byte(8'h38);
    send_byte(8'h44); send_byte(8'h31);
    send_byte(8'h45); send_byte(8'h32);
    check("cfg_data", seg_data,         24'h000698);
    check("cfg_dot",  24'(seg_dot_en),  24'h20);
    check("cfg_en",   24'(seg_data_en), 24'h2F);
    send_byte(8'h42); send_byte(8'h31);
    send_byte(8'h52);
    check("sr_data", seg_data,         24'h0);
    check("sr_en",   24'(seg_data_en), 24'h3F);
    check("sr_dot",  24'(seg_dot_en),  24'h0);
    check("sr_busy", 24'(busy),        24'h0);
    repeat (9) @(negedge clk_in);
    check("sr_noblink", 24'(seg_data_en), 24'h3F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
